// File: rtl/rd_data_cmp_if.sv
// Bundle of the compare-packet, read-beat and result signals of rd_data_cmp.
// The slave modport is the comparator; the master modport is its environment.
interface rd_data_cmp_if #(
  parameter int AMM_DATA_W  = 128,
  parameter int AMM_ADDR_W  = 31,
  parameter int AMM_BURST_W = 11
) ();
  logic                   start_test_i;
  logic                   cmp_pkt_en_i;
  logic [AMM_ADDR_W-1:0]  cmp_addr_i;
  logic [AMM_BURST_W-1:0] cmp_words_i;
  logic [7:0]             cmp_pattern_i;
  logic                   cmp_mode_i;
  logic                   cmp_pkt_ready_o;
  logic                   readdatavalid_i;
  logic [AMM_DATA_W-1:0]  readdata_i;
  logic                   error_check_o;
  logic [AMM_ADDR_W-1:0]  err_addr_o;
  logic [7:0]             err_data_o;
  logic [7:0]             exp_data_o;
  logic                   protocol_err_o;
  logic                   cmp_block_busy_o;

  modport slave (
    input  start_test_i, cmp_pkt_en_i, cmp_addr_i, cmp_words_i, cmp_pattern_i,
           cmp_mode_i, readdatavalid_i, readdata_i,
    output cmp_pkt_ready_o, error_check_o, err_addr_o, err_data_o, exp_data_o,
           protocol_err_o, cmp_block_busy_o
  );

  modport master (
    output start_test_i, cmp_pkt_en_i, cmp_addr_i, cmp_words_i, cmp_pattern_i,
           cmp_mode_i, readdatavalid_i, readdata_i,
    input  cmp_pkt_ready_o, error_check_o, err_addr_o, err_data_o, exp_data_o,
           protocol_err_o, cmp_block_busy_o
  );
endinterface

// File: rtl/rd_data_cmp.sv
// Read-data comparator: queues compare packets, regenerates the expected
// pattern per read beat, compares in two pipeline stages and latches the
// first mismatch. start_test_i and rst_i both return everything to idle.
module rd_data_cmp #(
  parameter int AMM_DATA_W     = 128,
  parameter int AMM_ADDR_W     = 31,
  parameter int AMM_BURST_W    = 11,
  parameter int CMP_FIFO_DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  rd_data_cmp_if.slave bus
);
  localparam int DATA_B = AMM_DATA_W / 8;
  localparam int PTR_W  = $clog2(CMP_FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0]       FULL_CNT = CNT_W'(CMP_FIFO_DEPTH);
  localparam logic [CNT_W-1:0]       CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0]       PTR_ONE  = PTR_W'(1);
  localparam logic [AMM_BURST_W-1:0] WORD_ONE = AMM_BURST_W'(1);
  localparam logic [AMM_BURST_W-1:0] WORD_ZERO = {AMM_BURST_W{1'b0}};
  localparam logic [7:0]             DATA_B8  = 8'(DATA_B);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

  // packet FIFO storage
  logic [AMM_ADDR_W-1:0]  fifo_addr  [CMP_FIFO_DEPTH];
  logic [AMM_BURST_W-1:0] fifo_words [CMP_FIFO_DEPTH];
  logic [7:0]             fifo_seed  [CMP_FIFO_DEPTH];
  logic                   fifo_mode  [CMP_FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   ready;

  // burst tracker
  state_t                 state;
  logic [AMM_ADDR_W-1:0]  burst_addr;
  logic [AMM_BURST_W-1:0] burst_words, beat_idx;
  logic [7:0]             burst_seed;
  logic                   burst_mode;

  // compare pipeline
  logic                   s1_valid;
  logic [AMM_DATA_W-1:0]  s1_data, s1_exp;
  logic [AMM_ADDR_W-1:0]  s1_addr;
  logic                   s2_valid, s2_hit;
  logic [AMM_ADDR_W-1:0]  s2_addr;
  logic [7:0]             s2_rcv, s2_exp;

  // results
  logic                   error_check, protocol_err, busy;
  logic [AMM_ADDR_W-1:0]  err_addr;
  logic [7:0]             err_data, exp_data;

  // combinational control
  logic                   clr, fifo_empty, push, overflow, pop, accept, orphan;
  logic [AMM_ADDR_W-1:0]  sel_addr;
  logic [AMM_BURST_W-1:0] sel_words, sel_k;
  logic [7:0]             sel_seed, beat_base;
  logic                   sel_mode, sel_last, busy_nxt;
  logic [CNT_W-1:0]       cnt_nxt;
  state_t                 state_nxt;
  logic [AMM_DATA_W-1:0]  exp_vec;
  logic                   cmp_hit, byte_diff;
  logic [7:0]             cmp_rcv, cmp_exp;

  // Beat/packet decode: a beat in IDLE starts a burst from the FIFO head, in BURST it continues the stored one.
  always_comb begin
    clr        = rst_i || bus.start_test_i;
    fifo_empty = (count == CNT_ZERO);
    push       = bus.cmp_pkt_en_i && ready;
    overflow   = bus.cmp_pkt_en_i && !ready;
    if (state == ST_IDLE) begin
      pop       = bus.readdatavalid_i && !fifo_empty;
      accept    = pop;
      orphan    = bus.readdatavalid_i && fifo_empty;
      sel_addr  = fifo_addr[rd_ptr];
      sel_words = (fifo_words[rd_ptr] == WORD_ZERO) ? WORD_ONE : fifo_words[rd_ptr];
      sel_seed  = fifo_seed[rd_ptr];
      sel_mode  = fifo_mode[rd_ptr];
      sel_k     = WORD_ZERO;
    end else begin
      pop       = 1'b0;
      accept    = bus.readdatavalid_i;
      orphan    = 1'b0;
      sel_addr  = burst_addr;
      sel_words = burst_words;
      sel_seed  = burst_seed;
      sel_mode  = burst_mode;
      sel_k     = beat_idx;
    end
    sel_last = (sel_k == (sel_words - WORD_ONE));
    cnt_nxt  = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    if (accept) begin
      state_nxt = sel_last ? ST_IDLE : ST_BURST;
    end else begin
      state_nxt = state;
    end
    busy_nxt = (cnt_nxt != CNT_ZERO) || (state_nxt == ST_BURST) || accept || s1_valid;
  end

  // Expected pattern for the current beat: fixed seed, or a byte ramp continuing across beats.
  always_comb begin
    exp_vec   = {AMM_DATA_W{1'b0}};
    beat_base = sel_k[7:0] * DATA_B8;
    for (int j = 0; j < DATA_B; j++) begin
      if (sel_mode) begin
        exp_vec[j*8 +: 8] = sel_seed + beat_base + 8'(j);
      end else begin
        exp_vec[j*8 +: 8] = sel_seed;
      end
    end
  end

  // Byte compare of stage 1; scanning downward lets the lowest mismatching byte win.
  always_comb begin
    cmp_hit   = 1'b0;
    cmp_rcv   = 8'h00;
    cmp_exp   = 8'h00;
    byte_diff = 1'b0;
    for (int j = DATA_B - 1; j >= 0; j--) begin
      byte_diff = (s1_data[j*8 +: 8] != s1_exp[j*8 +: 8]);
      cmp_hit   = cmp_hit | byte_diff;
      cmp_rcv   = byte_diff ? s1_data[j*8 +: 8] : cmp_rcv;
      cmp_exp   = byte_diff ? s1_exp[j*8 +: 8]  : cmp_exp;
    end
  end

  // Packet FIFO payload write; the storage itself needs no reset.
  always_ff @(posedge clk_i) begin
    if (push && !clr) begin
      fifo_addr[wr_ptr]  <= bus.cmp_addr_i;
      fifo_words[wr_ptr] <= bus.cmp_words_i;
      fifo_seed[wr_ptr]  <= bus.cmp_pattern_i;
      fifo_mode[wr_ptr]  <= bus.cmp_mode_i;
    end
  end

  // FIFO pointers, burst FSM, compare pipeline and sticky results.
  always_ff @(posedge clk_i) begin
    if (clr) begin
      wr_ptr       <= {PTR_W{1'b0}};
      rd_ptr       <= {PTR_W{1'b0}};
      count        <= CNT_ZERO;
      ready        <= 1'b1;
      state        <= ST_IDLE;
      burst_addr   <= {AMM_ADDR_W{1'b0}};
      burst_words  <= WORD_ZERO;
      beat_idx     <= WORD_ZERO;
      burst_seed   <= 8'h00;
      burst_mode   <= 1'b0;
      s1_valid     <= 1'b0;
      s1_data      <= {AMM_DATA_W{1'b0}};
      s1_exp       <= {AMM_DATA_W{1'b0}};
      s1_addr      <= {AMM_ADDR_W{1'b0}};
      s2_valid     <= 1'b0;
      s2_hit       <= 1'b0;
      s2_addr      <= {AMM_ADDR_W{1'b0}};
      s2_rcv       <= 8'h00;
      s2_exp       <= 8'h00;
      error_check  <= 1'b0;
      err_addr     <= {AMM_ADDR_W{1'b0}};
      err_data     <= 8'h00;
      exp_data     <= 8'h00;
      protocol_err <= 1'b0;
      busy         <= 1'b0;
    end else begin
      count <= cnt_nxt;
      ready <= (cnt_nxt != FULL_CNT);
      busy  <= busy_nxt;
      state <= state_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (accept) begin
        burst_addr  <= sel_addr;
        burst_words <= sel_words;
        burst_seed  <= sel_seed;
        burst_mode  <= sel_mode;
        beat_idx    <= sel_k + WORD_ONE;
        s1_data     <= bus.readdata_i;
        s1_exp      <= exp_vec;
        s1_addr     <= sel_addr + AMM_ADDR_W'(sel_k);
      end
      s1_valid <= accept;
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_hit  <= cmp_hit;
        s2_addr <= s1_addr;
        s2_rcv  <= cmp_rcv;
        s2_exp  <= cmp_exp;
      end
      if (s2_valid && s2_hit && !error_check) begin
        error_check <= 1'b1;
        err_addr    <= s2_addr;
        err_data    <= s2_rcv;
        exp_data    <= s2_exp;
      end
      if (overflow || orphan) begin
        protocol_err <= 1'b1;
      end
    end
  end

  assign bus.cmp_pkt_ready_o  = ready;
  assign bus.error_check_o    = error_check;
  assign bus.err_addr_o       = err_addr;
  assign bus.err_data_o       = err_data;
  assign bus.exp_data_o       = exp_data;
  assign bus.protocol_err_o   = protocol_err;
  assign bus.cmp_block_busy_o = busy;
endmodule

// File: tb/tb_rd_data_cmp.sv
// Bench for rd_data_cmp: a behavioural model predicts the sticky error
// results per cycle into a queue; entries are compared two cycles later,
// matching the compare pipeline latency. Other outputs are checked inline.
module tb_rd_data_cmp;
  typedef struct {
    logic [30:0] addr;
    logic [10:0] words;
    logic [7:0]  seed;
    logic        mode;
  } pkt_t;

  typedef struct {
    logic        err;
    logic [30:0] addr;
    logic [7:0]  rcv;
    logic [7:0]  exp;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pkt_t mq[$];
  res_t sb[$];
  res_t m_res;
  pkt_t m_cur;
  pkt_t none;
  logic m_active;
  int   m_k, m_words;

  rd_data_cmp_if bus ();

  rd_data_cmp dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_byte(pkt_t p, int k, int j);
    if (p.mode) return 8'(int'(p.seed) + k * 16 + j);
    return p.seed;
  endfunction

  function automatic logic [127:0] good_beat(pkt_t p, int k);
    logic [127:0] d;
    for (int j = 0; j < 16; j++) d[8*j +: 8] = exp_byte(p, k, j);
    return d;
  endfunction

  task automatic model_clear();
    mq.delete();
    sb.delete();
    m_active = 1'b0;
    m_k = 0;
    m_words = 0;
    m_res = '{1'b0, 31'h0, 8'h00, 8'h00};
  endtask

  // One clock cycle of stimulus; the model predicts the sticky error state after this beat.
  task automatic step(input logic en, input pkt_t p, input logic v, input logic [127:0] d);
    int   cnt0;
    logic found;
    logic [7:0] eb;
    @(negedge clk);
    bus.cmp_pkt_en_i    = en;
    bus.cmp_addr_i      = p.addr;
    bus.cmp_words_i     = p.words;
    bus.cmp_pattern_i   = p.seed;
    bus.cmp_mode_i      = p.mode;
    bus.readdatavalid_i = v;
    bus.readdata_i      = d;
    cnt0 = mq.size();
    if (v && (m_active || cnt0 != 0)) begin
      if (!m_active) begin
        m_cur    = mq.pop_front();
        m_k      = 0;
        m_words  = (m_cur.words == 11'd0) ? 1 : int'(m_cur.words);
        m_active = 1'b1;
      end
      found = 1'b0;
      for (int j = 0; j < 16; j++) begin
        eb = exp_byte(m_cur, m_k, j);
        if (!found && d[8*j +: 8] !== eb) begin
          found = 1'b1;
          if (!m_res.err) m_res = '{1'b1, 31'(m_cur.addr + 31'(m_k)), d[8*j +: 8], eb};
        end
      end
      m_k++;
      if (m_k == m_words) m_active = 1'b0;
    end
    if (en && cnt0 < 8) mq.push_back(p);
    sb.push_back(m_res);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start_test_i    = 1'b1;
    bus.cmp_pkt_en_i    = 1'b1;
    bus.readdatavalid_i = 1'b1;
    @(negedge clk);
    bus.start_test_i    = 1'b0;
    bus.cmp_pkt_en_i    = 1'b0;
    bus.readdatavalid_i = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.cmp_pkt_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", bus.cmp_pkt_ready_o);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    checks++;
    if ({bus.error_check_o, bus.err_addr_o, bus.err_data_o, bus.exp_data_o, bus.protocol_err_o, bus.cmp_block_busy_o} !== 50'h0) begin
      errors++;
      $display("FAIL reset_outputs err=%b addr=%h d=%h e=%h perr=%b busy=%b want all 0",
               bus.error_check_o, bus.err_addr_o, bus.err_data_o, bus.exp_data_o, bus.protocol_err_o, bus.cmp_block_busy_o);
    end
  endtask

  task automatic test_fixed_pass();
    pkt_t p = '{31'h100, 11'd4, 8'hA5, 1'b0};
    res_t r;
    for (int c = 0; c < 9; c++) begin
      if (c == 0) step(1'b1, p, 1'b0, 128'h0);
      else if (c <= 4) step(1'b0, none, 1'b1, {16{8'hA5}});
      else step(1'b0, none, 1'b0, 128'h0);
      if (sb.size() > 2) begin
        r = sb.pop_front();
        checks++;
        if (bus.error_check_o !== r.err || bus.err_addr_o !== r.addr || bus.err_data_o !== r.rcv || bus.exp_data_o !== r.exp) begin
          errors++;
          $display("FAIL fixed_sb c=%0d got %b/%h/%h/%h want %b/%h/%h/%h", c, bus.error_check_o, bus.err_addr_o,
                   bus.err_data_o, bus.exp_data_o, r.err, r.addr, r.rcv, r.exp);
        end
      end
      if (c == 5 || c == 6) begin
        checks++;
        if (bus.cmp_block_busy_o !== (c == 5)) begin
          errors++;
          $display("FAIL fixed_busy c=%0d got %b want %b", c, bus.cmp_block_busy_o, (c == 5));
        end
      end
    end
    checks++;
    if (bus.error_check_o !== 1'b0) begin
      errors++;
      $display("FAIL fixed_no_error got %b want 0", bus.error_check_o);
    end
    sb.delete();
  endtask

  task automatic test_running_wrap();
    pkt_t p = '{31'h7FFFFFFF, 11'd2, 8'hF0, 1'b1};
    logic [127:0] d;
    res_t r;
    for (int c = 0; c < 7; c++) begin
      if (c == 0) step(1'b1, p, 1'b0, 128'h0);
      else if (c == 1) step(1'b0, none, 1'b1, good_beat(p, 0));
      else if (c == 2) begin
        d = good_beat(p, 1);
        d[8*3 +: 8] = 8'h55;
        step(1'b0, none, 1'b1, d);
      end else step(1'b0, none, 1'b0, 128'h0);
      if (sb.size() > 2) begin
        r = sb.pop_front();
        checks++;
        if (bus.error_check_o !== r.err || bus.err_addr_o !== r.addr || bus.err_data_o !== r.rcv || bus.exp_data_o !== r.exp) begin
          errors++;
          $display("FAIL wrap_sb c=%0d got %b/%h/%h/%h want %b/%h/%h/%h", c, bus.error_check_o, bus.err_addr_o,
                   bus.err_data_o, bus.exp_data_o, r.err, r.addr, r.rcv, r.exp);
        end
      end
    end
    checks++;
    if (bus.error_check_o !== 1'b1 || bus.err_addr_o !== 31'h0 || bus.err_data_o !== 8'h55 || bus.exp_data_o !== 8'h03) begin
      errors++;
      $display("FAIL wrap_latched got %b/%h/%h/%h want 1/00000000/55/03", bus.error_check_o, bus.err_addr_o, bus.err_data_o, bus.exp_data_o);
    end
    sb.delete();
  endtask

  task automatic test_first_latch();
    pkt_t a = '{31'h200, 11'd1, 8'h11, 1'b0};
    pkt_t b = '{31'h300, 11'd2, 8'h22, 1'b1};
    logic [127:0] d;
    res_t r;
    pulse_start();
    for (int c = 0; c < 8; c++) begin
      if (c == 0) step(1'b1, a, 1'b0, 128'h0);
      else if (c == 1) begin
        d = good_beat(a, 0);
        d[8*5 +: 8] = 8'h99;
        d[8*9 +: 8] = 8'h77;
        step(1'b1, b, 1'b1, d);
      end else if (c == 2) step(1'b0, none, 1'b1, good_beat(b, 0));
      else if (c == 3) begin
        d = good_beat(b, 1);
        d[7:0] = 8'h00;
        step(1'b0, none, 1'b1, d);
      end else step(1'b0, none, 1'b0, 128'h0);
      if (sb.size() > 2) begin
        r = sb.pop_front();
        checks++;
        if (bus.error_check_o !== r.err || bus.err_addr_o !== r.addr || bus.err_data_o !== r.rcv || bus.exp_data_o !== r.exp) begin
          errors++;
          $display("FAIL latch_sb c=%0d got %b/%h/%h/%h want %b/%h/%h/%h", c, bus.error_check_o, bus.err_addr_o,
                   bus.err_data_o, bus.exp_data_o, r.err, r.addr, r.rcv, r.exp);
        end
      end
    end
    checks++;
    if (bus.err_addr_o !== 31'h200 || bus.err_data_o !== 8'h99 || bus.exp_data_o !== 8'h11) begin
      errors++;
      $display("FAIL latch_first got %h/%h/%h want 00000200/99/11", bus.err_addr_o, bus.err_data_o, bus.exp_data_o);
    end
    pulse_start();
    checks++;
    if ({bus.error_check_o, bus.err_addr_o, bus.err_data_o, bus.exp_data_o, bus.protocol_err_o, bus.cmp_block_busy_o} !== 50'h0
        || bus.cmp_pkt_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL start_clear err=%b addr=%h d=%h e=%h perr=%b busy=%b ready=%b want zeros and ready 1", bus.error_check_o,
               bus.err_addr_o, bus.err_data_o, bus.exp_data_o, bus.protocol_err_o, bus.cmp_block_busy_o, bus.cmp_pkt_ready_o);
    end
  endtask

  task automatic test_fifo_full();
    pkt_t p;
    for (int i = 0; i < 8; i++) begin
      p = '{31'(32'h400 + i * 4), (i == 3) ? 11'd0 : 11'd1, 8'(i * 17), 1'(i)};
      step(1'b1, p, 1'b0, 128'h0);
      if (i >= 6) begin
        checks++;
        if (bus.cmp_pkt_ready_o !== (i == 6)) begin
          errors++;
          $display("FAIL full_ready push=%0d got %b want %b", i + 1, bus.cmp_pkt_ready_o, (i == 6));
        end
      end
    end
    p = '{31'h7F0, 11'd1, 8'hEE, 1'b0};
    step(1'b1, p, 1'b0, 128'h0);
    checks++;
    if (bus.protocol_err_o !== 1'b1 || bus.cmp_pkt_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL full_overflow perr=%b ready=%b want 1/0", bus.protocol_err_o, bus.cmp_pkt_ready_o);
    end
    for (int i = 0; i < 8; i++) step(1'b0, none, 1'b1, good_beat(mq[0], 0));
    for (int i = 0; i < 3; i++) step(1'b0, none, 1'b0, 128'h0);
    checks++;
    if (bus.cmp_pkt_ready_o !== 1'b1 || bus.cmp_block_busy_o !== 1'b0 || bus.error_check_o !== 1'b0) begin
      errors++;
      $display("FAIL full_drain ready=%b busy=%b err=%b want 1/0/0", bus.cmp_pkt_ready_o, bus.cmp_block_busy_o, bus.error_check_o);
    end
    sb.delete();
  endtask

  task automatic test_orphan();
    pulse_start();
    step(1'b0, none, 1'b1, 128'h0);
    checks++;
    if (bus.protocol_err_o !== 1'b1) begin
      errors++;
      $display("FAIL orphan_perr got %b want 1", bus.protocol_err_o);
    end
    for (int i = 0; i < 3; i++) step(1'b0, none, 1'b0, 128'h0);
    checks++;
    if (bus.error_check_o !== 1'b0 || bus.cmp_block_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL orphan_quiet err=%b busy=%b want 0/0", bus.error_check_o, bus.cmp_block_busy_o);
    end
    sb.delete();
  endtask

  task automatic test_reset_midburst();
    pkt_t p = '{31'h500, 11'd4, 8'h3C, 1'b1};
    pulse_start();
    step(1'b1, p, 1'b0, 128'h0);
    step(1'b0, none, 1'b1, good_beat(p, 0));
    step(1'b0, none, 1'b1, good_beat(p, 1));
    @(negedge clk);
    rst = 1'b1;
    bus.readdatavalid_i = 1'b1;
    bus.readdata_i = good_beat(p, 2);
    @(posedge clk);
    #1;
    checks++;
    if (bus.cmp_block_busy_o !== 1'b0 || bus.protocol_err_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle busy=%b perr=%b want 0/0", bus.cmp_block_busy_o, bus.protocol_err_o);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.readdatavalid_i = 1'b0;
    model_clear();
    step(1'b0, none, 1'b1, good_beat(p, 3));
    checks++;
    if (bus.protocol_err_o !== 1'b1) begin
      errors++;
      $display("FAIL midrst_unexpected perr=%b want 1", bus.protocol_err_o);
    end
    for (int i = 0; i < 3; i++) step(1'b0, none, 1'b0, 128'h0);
    checks++;
    if (bus.error_check_o !== 1'b0 || bus.cmp_block_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_quiet err=%b busy=%b want 0/0", bus.error_check_o, bus.cmp_block_busy_o);
    end
    sb.delete();
  endtask

  initial begin
    none = '{31'h0, 11'd0, 8'h00, 1'b0};
    bus.start_test_i    = 1'b0;
    bus.cmp_pkt_en_i    = 1'b0;
    bus.cmp_addr_i      = 31'h0;
    bus.cmp_words_i     = 11'd0;
    bus.cmp_pattern_i   = 8'h00;
    bus.cmp_mode_i      = 1'b0;
    bus.readdatavalid_i = 1'b0;
    bus.readdata_i      = 128'h0;
    model_clear();
    repeat (2) @(posedge clk);
    test_reset();
    test_fixed_pass();
    test_running_wrap();
    test_first_latch();
    test_fifo_full();
    test_orphan();
    test_reset_midburst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
